// File: rtl/task2.sv
// RC4 key-scheduling engine: fills a 256x8 S-box with the identity permutation,
// then permutes it with a 24-bit key built from the slide switches.
module task2 (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  typedef enum logic [3:0] {
    INIT, RD_I, WT_I, CALC_J, WT_J, WR_I, WR_J, NEXT, DONE
  } state_e;

  logic        rst;
  logic        unused_keys;
  state_e      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [7:0]  si_q, si_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  kbyte;
  logic [7:0]  addr, wdata, q;
  logic        wren;

  assign rst         = ~KEY[3];
  assign unused_keys = ^KEY[2:0];

  s_mem s (
    .clock   (CLOCK_50),
    .address (addr),
    .data    (wdata),
    .wren    (wren),
    .q       (q)
  );

  always_comb begin
    case (kidx_q)
      2'd0:    kbyte = key_q[23:16];
      2'd1:    kbyte = key_q[15:8];
      default: kbyte = key_q[7:0];
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      kidx_q  <= 2'd0;
      si_q    <= 8'd0;
      key_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      key_q   <= key_d;
    end
  end

  // The RAM read is registered: an address presented in one state yields q
  // in the next, so every read is followed by a wait state holding the address.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    key_d   = key_q;
    addr    = i_q;
    wdata   = si_q;
    wren    = 1'b0;
    case (state_q)
      INIT: begin
        // first cycle out of reset captures the switches as the key
        if (i_q == 8'd0) key_d = {14'b0, SW};
        wdata = i_q;
        wren  = 1'b1;
        i_d   = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = RD_I;
      end
      RD_I:   state_d = WT_I;
      WT_I:   state_d = CALC_J;
      CALC_J: begin
        si_d    = q;
        j_d     = j_q + q + kbyte;
        addr    = j_d;
        state_d = WT_J;
      end
      WT_J: begin
        addr    = j_q;
        state_d = WR_I;
      end
      WR_I: begin
        wdata   = q;
        wren    = 1'b1;
        state_d = WR_J;
      end
      WR_J: begin
        addr    = j_q;
        wdata   = si_q;
        wren    = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
        state_d = (i_q == 8'hFF) ? DONE : RD_I;
      end
      DONE:    state_d = DONE;
      default: state_d = INIT;
    endcase
  end

  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
  assign LEDR = {9'd0, state_q == DONE};

endmodule

// Single-port 256x8 RAM with registered read (read-before-write on same address).
module s_mem (
  input  logic       clock,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);

  logic [7:0] mem [0:255];

  always_ff @(posedge clock) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end

endmodule

// File: tb/tb_task2.sv
// Directed checks of task2: identity fill, RC4 KSA result for several keys,
// reset abort/restart, switch capture on reset only, constant outputs.
module tb_task2;

  logic       clk;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  logic [7:0] exp_s [0:255];

  task2 dut (
    .CLOCK_50 (clk),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // outputs that must stay constant in every run
  always @(negedge clk)
    if ({HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} != {6{7'h7F}} || LEDR[9:1] != 9'd0)
      viol++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ksa_model(input logic [23:0] k);
    logic [7:0] kb [0:2];
    logic [7:0] j, t;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      j = 8'(j + exp_s[i] + kb[i % 3]);
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  // hold reset 5 cycles with the given switches, then release between edges
  task automatic do_reset(input logic [9:0] sw);
    @(negedge clk);
    KEY = 4'b0111;
    SW  = sw;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ledr", 32'(LEDR), 32'd0);
    chk("rst_hex0", 32'(HEX0), 32'h7F);
    @(negedge clk);
    KEY = 4'b1111;
  endtask

  task automatic wait_done(input string tag, input int start_cyc);
    int cyc;
    cyc = start_cyc;
    while (cyc < 4000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (LEDR[0]) break;
    end
    chk({tag, "_done"}, 32'(LEDR[0]), 32'd1);
    chk({tag, "_cycles_le_3000"}, 32'(cyc <= 3000), 32'd1);
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.s.mem[i] !== exp_s[i]) begin
        if (bad < 4)
          $display("FAIL %s S[%0d] got %0h expected %0h", tag, i, dut.s.mem[i], exp_s[i]);
        bad++;
      end
    end
    chk({tag, "_mismatch_count"}, 32'(bad), 32'd0);
  endtask

  initial begin
    KEY = 4'b1111;
    SW  = 10'h000;

    // run 1: key 00 01 55, identity probe at 256 cycles, then full KSA
    do_reset(10'h155);
    repeat (256) @(posedge clk);
    #1;
    chk("init_ledr0", 32'(LEDR[0]), 32'd0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (dut.s.mem[i] !== 8'(i)) bad++;
      chk("init_identity_bad", 32'(bad), 32'd0);
    end
    chk("init_s0", 32'(dut.s.mem[0]), 32'h00);
    chk("init_s255", 32'(dut.s.mem[255]), 32'hFF);
    wait_done("k155", 256);
    ksa_model(24'h000155);
    cmp_mem("k155");
    repeat (20) @(posedge clk);
    #1;
    chk("k155_done_held", 32'(LEDR[0]), 32'd1);
    cmp_mem("k155_held");
    chk("k155_viol", 32'(viol), 32'd0);

    // run 2: all-zero key; switches changed mid-run must be ignored
    do_reset(10'h000);
    repeat (100) @(posedge clk);
    @(negedge clk);
    SW = 10'h3FF;
    wait_done("k000", 100);
    ksa_model(24'h000000);
    chk("k000_s2", 32'(exp_s[2]), 32'(dut.s.mem[2]));
    cmp_mem("k000");
    chk("k000_viol", 32'(viol), 32'd0);

    // run 3: abort at ~1000 cycles with new switches, restart and finish
    do_reset(10'h155);
    repeat (1000) @(posedge clk);
    #1;
    chk("abort_pre_ledr0", 32'(LEDR[0]), 32'd0);
    do_reset(10'h3FF);
    #1;
    wait_done("k3ff", 0);
    ksa_model(24'h0003FF);
    cmp_mem("k3ff");
    chk("k3ff_viol", 32'(viol), 32'd0);

    // reset after DONE drops the flag
    @(negedge clk);
    KEY = 4'b0111;
    #1;
    chk("post_done_rst_ledr0", 32'(LEDR[0]), 32'd0);
    @(negedge clk);
    KEY = 4'b1111;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
